side_road_detector: RTL

SIDE_ROAD_DETECTOR -- requirements
Module: side_road_detector

---
 rtl/side_road_detector.sv | 131 +++++++++++++
 1 files changed

// File: rtl/side_road_detector.sv
// Side-road vehicle detector: synchronizes and debounces the loop sensor, counts
// waiting vehicles and requests/acknowledges side-road green from the light controller.
//
// state   | meaning
// IDLE    | no vehicle waiting, no request
// REQUEST | vehicles waiting, sensor asserted until green arrives
// SERVING | side-road green active, counting green cycles
// CLEAR   | service completed, served pulse for one cycle
module side_road_detector #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned MIN_SERVE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loop_raw,
  input  logic       SG,
  input  logic       SR,
  output logic       sensor,
  output logic [7:0] veh_count,
  output logic       served,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVING = 2'd2,
    CLEAR   = 2'd3
  } state_e;

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [3:0] SERVE_MIN = 4'(MIN_SERVE);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] db_cnt_q, db_cnt_d;
  logic       filt_prev_q;
  logic       arrive_q;
  state_e     state_q, state_d;
  logic [3:0] serve_cnt_q, serve_cnt_d;
  logic [7:0] veh_q, veh_d, veh_inc;
  logic       fault_q;

  // Any sample agreeing with the filtered level restarts the debounce window.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 4'd1;
      end
    end
  end

  assign veh_inc = (veh_q == 8'hFF) ? veh_q : veh_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    veh_d       = veh_q;
    case (state_q)
      IDLE: begin
        if (arrive_q) begin
          state_d = REQUEST;
          veh_d   = veh_inc;
        end
      end
      REQUEST: begin
        if (arrive_q) veh_d = veh_inc;
        if (SG) begin
          state_d     = SERVING;
          serve_cnt_d = '0;
        end
      end
      SERVING: begin
        // Arrivals are ignored here: the vehicle drives through on green.
        if (SG) begin
          if (serve_cnt_q != 4'hF) serve_cnt_d = serve_cnt_q + 4'd1;
        end else if (serve_cnt_q >= SERVE_MIN) begin
          state_d = CLEAR;
          veh_d   = '0;
        end else begin
          state_d = REQUEST;
        end
      end
      CLEAR: begin
        if (arrive_q) begin
          state_d = REQUEST;
          veh_d   = veh_inc;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      db_cnt_q    <= '0;
      filt_prev_q <= 1'b0;
      arrive_q    <= 1'b0;
      state_q     <= IDLE;
      serve_cnt_q <= '0;
      veh_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      sync1_q     <= loop_raw;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      db_cnt_q    <= db_cnt_d;
      filt_prev_q <= filt_q;
      arrive_q    <= filt_q & ~filt_prev_q;
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      veh_q       <= veh_d;
      fault_q     <= fault_q | (SG == SR);
    end
  end

  assign sensor    = (state_q == REQUEST) || (state_q == SERVING);
  assign served    = (state_q == CLEAR);
  assign veh_count = veh_q;
  assign fault     = fault_q;

endmodule
